// File: rtl/fatori_fault_escalator_if.sv
// Alert inputs and status outputs of the fatori fault escalator, grouped
// into one bundle. The escalator uses the slave view; the system side that
// raises alerts and reads status uses the master view.
interface fatori_fault_escalator_if #(
    parameter int N_MINOR = 4,
    parameter int N_MAJOR = 3,
    parameter int CNT_W   = 16,
    parameter int DUMP_W  = 160
);
    localparam int FM_W = $clog2(N_MAJOR + 1);

    // alert side
    logic [N_MINOR-1:0]       minor_i;
    logic [N_MAJOR-1:0]       major_i;
    logic                     clr_i;
    logic                     core_sleep_i;
    logic [DUMP_W-1:0]        crash_dump_i;

    // status / control side
    logic [3:0]               fetch_enable_o;
    logic                     core_reset_req_o;
    logic [N_MINOR-1:0]       minor_seen_o;
    logic [N_MAJOR-1:0]       major_seen_o;
    logic [N_MINOR*CNT_W-1:0] minor_cnt_o;
    logic [CNT_W-1:0]         major_cnt_o;
    logic [FM_W-1:0]          first_major_o;
    logic                     sleep_tmo_o;
    logic [2:0]               state_o;
    logic [DUMP_W-1:0]        crash_dump_o;

    modport slave (
        input  minor_i, major_i, clr_i, core_sleep_i, crash_dump_i,
        output fetch_enable_o, core_reset_req_o, minor_seen_o, major_seen_o,
               minor_cnt_o, major_cnt_o, first_major_o, sleep_tmo_o, state_o,
               crash_dump_o
    );

    modport master (
        output minor_i, major_i, clr_i, core_sleep_i, crash_dump_i,
        input  fetch_enable_o, core_reset_req_o, minor_seen_o, major_seen_o,
               minor_cnt_o, major_cnt_o, first_major_o, sleep_tmo_o, state_o,
               crash_dump_o
    );
endinterface

// File: rtl/fatori_fault_escalator.sv
// Multi-channel fault manager beside the Ibex core.
// Counts minor/major alerts per channel (saturating, sticky flags), turns
// repeated minor alerts into a major event, and on the first major event
// halts fetch, waits for core sleep (bounded), then requests a timed reset.
// All state lives in one record stored three times and majority-voted.
// Optional feature: define FATORI_FM_CRASH_LATCH_EN to latch the crash dump
// on the first major event; otherwise crash_dump_o is tied to zero.
module fatori_fault_escalator #(
    parameter int N_MINOR        = 4,
    parameter int N_MAJOR        = 3,
    parameter int CNT_W          = 16,
    parameter int MINOR_ESC_TH   = 8,
    parameter bit RESET_ON_MAJOR = 1'b1,
    parameter bit WAIT_SLEEP     = 1'b1,
    parameter int SLEEP_TMO      = 1024,
    parameter int RST_LEN        = 4,
    parameter int DUMP_W         = 160
) (
    input  logic clk_i,
    input  logic rst_i,
    fatori_fault_escalator_if.slave bus
);

    localparam int FM_W    = $clog2(N_MAJOR + 1);
    localparam int TMR_MAX = (SLEEP_TMO > RST_LEN) ? SLEEP_TMO : RST_LEN;
    localparam int TM_W    = $clog2(TMR_MAX + 1);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [32:0]      ESC_TH  = 33'(MINOR_ESC_TH);
    localparam bit               ESC_EN  = (MINOR_ESC_TH != 0);

    // Ibex multi-bit boolean encodings for fetch enable
    localparam logic [3:0] MUBI_ON  = 4'b0101;
    localparam logic [3:0] MUBI_OFF = 4'b1010;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_HALT  = 3'd1,
        ST_WAIT  = 3'd2,
        ST_RESET = 3'd3,
        ST_LOCK  = 3'd4
    } state_e;

    // Complete state record; every field resets to zero (IDLE, fetch on).
    typedef struct packed {
        state_e                   state;
        logic [TM_W-1:0]          timer;
        logic                     fetch_off;
        logic                     sleep_tmo;
        logic [N_MINOR-1:0]       minor_seen;
        logic [N_MAJOR-1:0]       major_seen;
        logic [N_MINOR*CNT_W-1:0] minor_cnt;
        logic [CNT_W-1:0]         major_cnt;
        logic [CNT_W-1:0]         esc_cnt;
        logic                     fm_vld;
        logic [FM_W-1:0]          first_major;
`ifdef FATORI_FM_CRASH_LATCH_EN
        logic [DUMP_W-1:0]        dump;
`endif
    } regs_t;

    // Saturating add of a small increment to a counter value.
    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                 input logic [5:0]       b);
        logic [32:0] s;
        s = 33'(a) + 33'(b);
        if (s > 33'(CNT_MAX)) begin
            return CNT_MAX;
        end
        return s[CNT_W-1:0];
    endfunction

    // Number of minor alert bits set this cycle (at most 16).
    function automatic logic [5:0] popcnt(input logic [N_MINOR-1:0] v);
        logic [5:0] n;
        n = '0;
        for (int i = 0; i < N_MINOR; i++) begin
            n = n + 6'(v[i]);
        end
        return n;
    endfunction

    // Lowest set major channel; N_MAJOR when none is set (escalation only).
    function automatic logic [FM_W-1:0] first_idx(input logic [N_MAJOR-1:0] v);
        logic [FM_W-1:0] idx;
        idx = FM_W'(N_MAJOR);
        for (int i = N_MAJOR - 1; i >= 0; i--) begin
            if (v[i]) begin
                idx = FM_W'(i);
            end
        end
        return idx;
    endfunction

    regs_t r_a, r_b, r_c;
    regs_t w_q, w_d;

    logic                     w_esc_pulse;
    logic                     w_major_evt;
    logic                     w_first_evt;
    logic                     w_tmo_set;
    logic                     w_illegal;
    state_e                   w_state_d;
    logic [TM_W-1:0]          w_timer_d;
    logic [N_MINOR*CNT_W-1:0] w_minor_cnt_d;
    logic [N_MINOR-1:0]       w_minor_seen_d;
    logic [N_MAJOR-1:0]       w_major_seen_d;
    logic [CNT_W-1:0]         w_major_cnt_d;
    logic [CNT_W-1:0]         w_esc_cnt_d;
    logic                     w_fm_vld_d;
    logic [FM_W-1:0]          w_first_major_d;

    // Majority vote across the three stored copies.
    assign w_q = regs_t'((r_a & r_b) | (r_b & r_c) | (r_a & r_c));

    // Escalation fires for one cycle once the accumulated minor count has
    // reached the threshold; it is folded into the major event.
    assign w_esc_pulse = ESC_EN && (33'(w_q.esc_cnt) >= ESC_TH);
    assign w_major_evt = (|bus.major_i) | w_esc_pulse;
    assign w_first_evt = w_major_evt && !w_q.fetch_off;

    // State register: three identical copies, synchronous reset to zero.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_a <= '0;
            r_b <= '0;
            r_c <= '0;
        end else begin
            r_a <= w_d;
            r_b <= w_d;
            r_c <= w_d;
        end
    end

    // FSM next state and shared WAIT/RESET cycle timer.
    always_comb begin
        w_state_d = w_q.state;
        w_timer_d = w_q.timer;
        w_tmo_set = 1'b0;
        w_illegal = 1'b0;
        case (w_q.state)
            ST_IDLE: begin
                if (w_major_evt) begin
                    w_state_d = ST_HALT;
                end
            end
            ST_HALT: begin
                if (RESET_ON_MAJOR) begin
                    w_timer_d = '0;
                    w_state_d = WAIT_SLEEP ? ST_WAIT : ST_RESET;
                end
            end
            ST_WAIT: begin
                // sleep has priority over a timeout in the same cycle
                if (bus.core_sleep_i) begin
                    w_state_d = ST_RESET;
                    w_timer_d = '0;
                end else if (w_q.timer == TM_W'(SLEEP_TMO - 1)) begin
                    w_state_d = ST_RESET;
                    w_timer_d = '0;
                    w_tmo_set = 1'b1;
                end else begin
                    w_timer_d = w_q.timer + TM_W'(1);
                end
            end
            ST_RESET: begin
                if (w_q.timer == TM_W'(RST_LEN - 1)) begin
                    w_state_d = ST_LOCK;
                end else begin
                    w_timer_d = w_q.timer + TM_W'(1);
                end
            end
            ST_LOCK: begin
                w_state_d = ST_LOCK;
            end
            default: begin
                // corrupted encoding: park safely with fetch disabled
                w_state_d = ST_LOCK;
                w_illegal = 1'b1;
            end
        endcase
    end

    // Per-channel counters, sticky flags and escalation accumulator.
    // A clear in the same cycle as an event restarts from that event.
    always_comb begin
        w_minor_cnt_d  = w_q.minor_cnt;
        w_minor_seen_d = bus.clr_i ? bus.minor_i : (w_q.minor_seen | bus.minor_i);
        w_major_seen_d = bus.clr_i ? bus.major_i : (w_q.major_seen | bus.major_i);
        for (int i = 0; i < N_MINOR; i++) begin
            w_minor_cnt_d[i*CNT_W +: CNT_W] =
                sat_add(bus.clr_i ? {CNT_W{1'b0}} : w_q.minor_cnt[i*CNT_W +: CNT_W],
                        6'(bus.minor_i[i]));
        end
        w_major_cnt_d = sat_add(bus.clr_i ? {CNT_W{1'b0}} : w_q.major_cnt,
                                6'(w_major_evt));
        if (w_esc_pulse) begin
            w_esc_cnt_d = '0;
        end else begin
            w_esc_cnt_d = sat_add(bus.clr_i ? {CNT_W{1'b0}} : w_q.esc_cnt,
                                  popcnt(bus.minor_i));
        end
    end

    // First-cause capture; re-armed by clear, but a same-cycle event wins.
    always_comb begin
        w_fm_vld_d      = w_q.fm_vld;
        w_first_major_d = w_q.first_major;
        if (w_major_evt && (!w_q.fm_vld || bus.clr_i)) begin
            w_fm_vld_d      = 1'b1;
            w_first_major_d = first_idx(bus.major_i);
        end else if (bus.clr_i) begin
            w_fm_vld_d      = 1'b0;
            w_first_major_d = '0;
        end
    end

    // Assemble the next state record.
    always_comb begin
        w_d             = '0;
        w_d.state       = w_state_d;
        w_d.timer       = w_timer_d;
        w_d.fetch_off   = w_q.fetch_off | w_major_evt | w_illegal;
        w_d.sleep_tmo   = w_q.sleep_tmo | w_tmo_set;
        w_d.minor_seen  = w_minor_seen_d;
        w_d.major_seen  = w_major_seen_d;
        w_d.minor_cnt   = w_minor_cnt_d;
        w_d.major_cnt   = w_major_cnt_d;
        w_d.esc_cnt     = w_esc_cnt_d;
        w_d.fm_vld      = w_fm_vld_d;
        w_d.first_major = w_first_major_d;
`ifdef FATORI_FM_CRASH_LATCH_EN
        w_d.dump        = w_first_evt ? bus.crash_dump_i : w_q.dump;
`endif
    end

    assign bus.fetch_enable_o   = w_q.fetch_off ? MUBI_OFF : MUBI_ON;
    assign bus.core_reset_req_o = (w_q.state == ST_RESET);
    assign bus.minor_seen_o     = w_q.minor_seen;
    assign bus.major_seen_o     = w_q.major_seen;
    assign bus.minor_cnt_o      = w_q.minor_cnt;
    assign bus.major_cnt_o      = w_q.major_cnt;
    assign bus.first_major_o    = w_q.first_major;
    assign bus.sleep_tmo_o      = w_q.sleep_tmo;
    assign bus.state_o          = w_q.state;

`ifdef FATORI_FM_CRASH_LATCH_EN
    logic w_unused_first;
    assign w_unused_first   = 1'b0;
    assign bus.crash_dump_o = w_q.dump;
`else
    logic w_unused_first;
    logic w_unused_dump;
    assign w_unused_first   = w_first_evt;
    assign w_unused_dump    = ^bus.crash_dump_i;
    assign bus.crash_dump_o = '0;
`endif

endmodule

// File: tb/tb_fatori_fault_escalator.sv
// Bench for fatori_fault_escalator: directed scenarios plus randomized
// episodes, every cycle compared against a timeline-based reference model.
module tb_fatori_fault_escalator;

    localparam int N_MINOR = 4;
    localparam int N_MAJOR = 3;
    localparam int CNT_W   = 4;
    localparam int ESC_TH  = 8;
    localparam int TMO     = 1024;
    localparam int RLEN    = 4;
    localparam int DUMP_W  = 160;
    localparam int CMAX    = (1 << CNT_W) - 1;
`ifdef FATORI_FM_CRASH_LATCH_EN
    localparam bit LATCH = 1'b1;
`else
    localparam bit LATCH = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fatori_fault_escalator_if #(.N_MINOR(N_MINOR), .N_MAJOR(N_MAJOR),
                                .CNT_W(CNT_W), .DUMP_W(DUMP_W)) u_if ();

    fatori_fault_escalator #(
        .N_MINOR(N_MINOR), .N_MAJOR(N_MAJOR), .CNT_W(CNT_W),
        .MINOR_ESC_TH(ESC_TH), .RESET_ON_MAJOR(1'b1), .WAIT_SLEEP(1'b1),
        .SLEEP_TMO(TMO), .RST_LEN(RLEN), .DUMP_W(DUMP_W)
    ) u_dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (u_if)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [191:0] got,
                            input logic [191:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: counts as plain integers, FSM as event timestamps.
    int                 m_cnt[N_MINOR];
    logic [N_MINOR-1:0] m_mseen;
    logic [N_MAJOR-1:0] m_majseen;
    int                 m_maj, m_esc, m_fm;
    bit                 m_fmv, m_off, m_tmo;
    logic [DUMP_W-1:0]  m_dump;
    int                 cyc, t_halt, t_wait, t_rst;

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < N_MINOR; i++) m_cnt[i] = 0;
        m_mseen = '0; m_majseen = '0;
        m_maj = 0; m_esc = 0; m_fm = 0;
        m_fmv = 0; m_off = 0; m_tmo = 0; m_dump = '0;
        cyc = 0; t_halt = -1; t_wait = -1; t_rst = -1;
    endfunction

    function automatic void model_step(input logic [N_MINOR-1:0] mi,
                                       input logic [N_MAJOR-1:0] ma,
                                       input logic cl, input logic sl,
                                       input logic [DUMP_W-1:0] dp);
        bit pulse, evt;
        int low;
        cyc++;
        pulse = (m_esc >= ESC_TH);
        evt   = (ma != 0) || pulse;
        for (int i = 0; i < N_MINOR; i++) begin
            m_cnt[i] = imin((cl ? 0 : m_cnt[i]) + int'(mi[i]), CMAX);
        end
        m_mseen   = cl ? mi : (m_mseen | mi);
        m_majseen = cl ? ma : (m_majseen | ma);
        m_maj     = imin((cl ? 0 : m_maj) + int'(evt), CMAX);
        m_esc     = pulse ? 0 : imin((cl ? 0 : m_esc) + $countones(mi), CMAX);
        if (evt && (!m_fmv || cl)) begin
            low = N_MAJOR;
            for (int i = N_MAJOR - 1; i >= 0; i--) if (ma[i]) low = i;
            m_fm = low; m_fmv = 1;
        end else if (cl) begin
            m_fm = 0; m_fmv = 0;
        end
        if (evt && !m_off) m_dump = dp;
        if (evt) m_off = 1;
        if (t_halt < 0 && evt) begin
            t_halt = cyc;
            t_wait = cyc + 1;
        end else if (t_wait >= 0 && t_rst < 0 && cyc > t_wait) begin
            if (sl) begin
                t_rst = cyc;
            end else if (cyc == t_wait + TMO) begin
                t_rst = cyc;
                m_tmo = 1;
            end
        end
    endfunction

    // 0 idle, 1 halt, 2 wait, 3 reset, 4 lock
    function automatic int exp_state();
        if (t_halt < 0) return 0;
        if (cyc == t_halt) return 1;
        if (t_rst < 0) return 2;
        if (cyc < t_rst + RLEN) return 3;
        return 4;
    endfunction

    task automatic compare_all();
        int es;
        es = exp_state();
        check_eq("state", u_if.state_o, es);
        check_eq("fetch", u_if.fetch_enable_o, m_off ? 4'b1010 : 4'b0101);
        check_eq("rst_req", u_if.core_reset_req_o, es == 3);
        for (int i = 0; i < N_MINOR; i++)
            check_eq("minor_cnt", u_if.minor_cnt_o[i*CNT_W +: CNT_W], m_cnt[i]);
        check_eq("minor_seen", u_if.minor_seen_o, m_mseen);
        check_eq("major_seen", u_if.major_seen_o, m_majseen);
        check_eq("major_cnt", u_if.major_cnt_o, m_maj);
        check_eq("first_major", u_if.first_major_o, m_fm);
        check_eq("sleep_tmo", u_if.sleep_tmo_o, m_tmo);
        check_eq("crash_dump", u_if.crash_dump_o, LATCH ? m_dump : '0);
    endtask

    task automatic cycle(input logic [N_MINOR-1:0] mi, input logic [N_MAJOR-1:0] ma,
                         input logic cl, input logic sl, input logic [DUMP_W-1:0] dp);
        u_if.minor_i      = mi;
        u_if.major_i      = ma;
        u_if.clr_i        = cl;
        u_if.core_sleep_i = sl;
        u_if.crash_dump_i = dp;
        @(posedge clk);
        model_step(mi, ma, cl, sl, dp);
        #1;
        compare_all();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        u_if.minor_i = '0; u_if.major_i = '0; u_if.clr_i = 1'b0;
        u_if.core_sleep_i = 1'b0; u_if.crash_dump_i = '0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        check_eq("rst_fetch", u_if.fetch_enable_o, 4'b0101);
        check_eq("rst_state", u_if.state_o, 0);
        check_eq("rst_cnt", u_if.minor_cnt_o, 0);
        check_eq("rst_first", u_if.first_major_o, 0);
        rst = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, n_hi;
        logic [DUMP_W-1:0] dp;
        logic [N_MINOR-1:0] mi;
        logic [N_MAJOR-1:0] ma;
        int sp_tab[4] = '{0, 2, 10, 0};
        int md_tab[4] = '{60, 25, 200, 8};

        rst = 1'b1;
        u_if.minor_i = '0; u_if.major_i = '0; u_if.clr_i = 1'b0;
        u_if.core_sleep_i = 1'b0; u_if.crash_dump_i = '0;

        // idle after reset
        do_reset();
        repeat (20) cycle('0, '0, 1'b0, 1'b0, '0);
        check_eq("idle_fetch", u_if.fetch_enable_o, 4'b0101);
        check_eq("idle_state", u_if.state_o, 0);
        check_eq("idle_majcnt", u_if.major_cnt_o, 0);

        // two major bits at once, sleep later, timed reset then lock
        do_reset();
        cycle('0, 3'b110, 1'b0, 1'b0, '0);
        check_eq("maj_fetch", u_if.fetch_enable_o, 4'b1010);
        check_eq("maj_cnt", u_if.major_cnt_o, 1);
        check_eq("maj_seen", u_if.major_seen_o, 3'b110);
        check_eq("maj_first", u_if.first_major_o, 1);
        repeat (3) cycle('0, '0, 1'b0, 1'b0, '0);
        check_eq("maj_wait", u_if.state_o, 2);
        n_hi = 0;
        for (int k = 0; k < 10; k++) begin
            cycle('0, '0, 1'b0, k == 0, '0);
            if (u_if.core_reset_req_o) n_hi++;
        end
        check_eq("rst_len", n_hi, RLEN);
        check_eq("lock", u_if.state_o, 4);

        // no sleep: timeout exactly TMO cycles after entering WAIT
        do_reset();
        cycle('0, 3'b001, 1'b0, 1'b0, '0);
        cycle('0, '0, 1'b0, 1'b0, '0);
        n = 0;
        while (u_if.state_o != 3'd3 && n < TMO + 50) begin
            cycle('0, '0, 1'b0, 1'b0, '0);
            n++;
        end
        check_eq("tmo_cycles", n, TMO);
        check_eq("tmo_flag", u_if.sleep_tmo_o, 1);

        // minor escalation
        do_reset();
        repeat (8) cycle(4'b0100, '0, 1'b0, 1'b0, '0);
        check_eq("esc_cnt2", u_if.minor_cnt_o[2*CNT_W +: CNT_W], 8);
        check_eq("esc_not_yet", u_if.fetch_enable_o, 4'b0101);
        cycle('0, '0, 1'b0, 1'b0, '0);
        check_eq("esc_first", u_if.first_major_o, N_MAJOR);
        check_eq("esc_fetch", u_if.fetch_enable_o, 4'b1010);
        check_eq("esc_majcnt", u_if.major_cnt_o, 1);

        // saturation and clear colliding with an event
        do_reset();
        repeat (20) cycle(4'b0001, '0, 1'b0, 1'b0, '0);
        check_eq("sat_cnt0", u_if.minor_cnt_o[CNT_W-1:0], CMAX);
        cycle(4'b0001, '0, 1'b1, 1'b0, '0);
        check_eq("clr_cnt0", u_if.minor_cnt_o[CNT_W-1:0], 1);
        check_eq("clr_seen", u_if.minor_seen_o, 4'b0001);

        // crash dump latch on first major only
        do_reset();
        dp = '0; dp[31:0] = 32'hDEAD_BEEF;
        cycle('0, 3'b001, 1'b0, 1'b0, dp);
        dp[31:0] = 32'h1234_5678;
        repeat (5) cycle('0, 3'b010, 1'b0, 1'b0, dp);
        dp = '0; dp[31:0] = 32'hDEAD_BEEF;
        check_eq("dump_hold", u_if.crash_dump_o, LATCH ? dp : '0);

        // randomized episodes
        for (int ep = 0; ep < 4; ep++) begin
            do_reset();
            for (int c = 0; c < 1200; c++) begin
                mi = N_MINOR'($urandom) & N_MINOR'($urandom);
                ma = ($urandom_range(0, md_tab[ep] - 1) == 0) ?
                     N_MAJOR'($urandom_range(1, 7)) : '0;
                dp = {$urandom, $urandom, $urandom, $urandom, $urandom};
                cycle(mi, ma, $urandom_range(0, 79) == 0,
                      $urandom_range(0, 99) < sp_tab[ep], dp);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
